// File: rtl/bus_master_if.sv
// Core-side request/response handshake for bus_master.
// The requester (CPU core or testbench) uses the master modport; the
// bus_master block itself answers on the slave modport.
interface bus_master_if;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;

  modport master (
    output req_valid,
    output req_write,
    output req_addr,
    output req_wdata,
    output req_size,
    output req_unsigned,
    input  req_ready,
    input  resp_valid,
    input  resp_rdata,
    input  resp_error
  );

  modport slave (
    input  req_valid,
    input  req_write,
    input  req_addr,
    input  req_wdata,
    input  req_size,
    input  req_unsigned,
    output req_ready,
    output resp_valid,
    output resp_rdata,
    output resp_error
  );
endinterface

// File: rtl/bus_master.sv
// bus_master: turns single load/store requests from a core into cycles on
// a shared 32-bit tristate peripheral bus. Sub-word stores are done as a
// read-modify-write so peripherals only ever see whole-word accesses.
module bus_master (
  input  logic               clk,
  input  logic               reset,
  bus_master_if.slave        core,
  inout  wire  [31:0]        data_bus_data,
  output logic [31:0]        data_bus_addr,
  output logic [1:0]         data_bus_mode
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RD     = 3'd1;
  localparam logic [2:0] ST_RMW_RD = 3'd2;
  localparam logic [2:0] ST_WR     = 3'd3;
  localparam logic [2:0] ST_RESP   = 3'd4;

  localparam logic [1:0] MODE_IDLE  = 2'b00;
  localparam logic [1:0] MODE_READ  = 2'b01;
  localparam logic [1:0] MODE_WRITE = 2'b10;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [2:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic [31:0] word_q, word_d;     // word driven during WR
  logic [31:0] rdata_q, rdata_d;   // load result presented in RESP
  logic        err_q, err_d;

  // Misaligned or illegal-size requests never reach the bus.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] off);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Pick the addressed little-endian lane out of a bus word and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [1:0]  size,
                                               input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: res = uns ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_HALF: res = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Replace only the addressed lane of the sampled word with store data.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  off,
                                              input logic [1:0]  size);
    logic [31:0] res;
    res = word;
    case (size)
      SZ_BYTE: res[{off, 3'b000} +: 8] = wdata[7:0];
      SZ_HALF: begin
        if (off[1]) res[31:16] = wdata[15:0];
        else        res[15:0]  = wdata[15:0];
      end
      default: res = wdata;
    endcase
    return res;
  endfunction

  // Next-state and datapath update for the transaction sequencer.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    word_d     = word_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        if (core.req_valid) begin
          addr_d     = core.req_addr;
          wdata_d    = core.req_wdata;
          size_d     = core.req_size;
          unsigned_d = core.req_unsigned;
          word_d     = core.req_wdata;
          rdata_d    = 32'h0;
          err_d      = 1'b0;
          if (is_misaligned(core.req_size, core.req_addr[1:0])) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else if (!core.req_write) begin
            state_d = ST_RD;
          end else if (core.req_size == SZ_WORD) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RMW_RD;
          end
        end
      end
      ST_RD: begin
        rdata_d = load_extract(data_bus_data, addr_q[1:0], size_q, unsigned_q);
        state_d = ST_RESP;
      end
      ST_RMW_RD: begin
        word_d  = store_merge(data_bus_data, wdata_q, addr_q[1:0], size_q);
        state_d = ST_WR;
      end
      ST_WR: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state; reset abandons any in-flight transaction at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request fields and data words; only observed through state-gated outputs.
  always_ff @(posedge clk) begin
    addr_q     <= addr_d;
    wdata_q    <= wdata_d;
    size_q     <= size_d;
    unsigned_q <= unsigned_d;
    word_q     <= word_d;
    rdata_q    <= rdata_d;
    err_q      <= err_d;
  end

  // Bus address/mode are pure decodes of the state so reset clears them instantly.
  always_comb begin
    data_bus_addr = 32'h0;
    data_bus_mode = MODE_IDLE;
    case (state_q)
      ST_RD, ST_RMW_RD: begin
        data_bus_addr = {addr_q[31:2], 2'b00};
        data_bus_mode = MODE_READ;
      end
      ST_WR: begin
        data_bus_addr = {addr_q[31:2], 2'b00};
        data_bus_mode = MODE_WRITE;
      end
      default: begin
        data_bus_addr = 32'h0;
        data_bus_mode = MODE_IDLE;
      end
    endcase
  end

  assign data_bus_data = (state_q == ST_WR) ? word_q : 32'hzzzz_zzzz;

  assign core.req_ready  = (state_q == ST_IDLE);
  assign core.resp_valid = (state_q == ST_RESP);
  assign core.resp_rdata = (state_q == ST_RESP) ? rdata_q : 32'h0;
  assign core.resp_error = (state_q == ST_RESP) ? err_q : 1'b0;

endmodule

// File: doc/bus_master.md
BUS_MASTER -- requirements
Module: bus_master

Interface
REQ-001 SHALL have no parameters; the bus width is fixed at 32 bits.
REQ-002 SHALL have port: clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: req_valid  input  1  core requests a load or store.
REQ-005 SHALL have port: req_write  input  1  1 = store, 0 = load.
REQ-006 SHALL have port: req_addr  input  32  byte address.
REQ-007 SHALL have port: req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-008 SHALL have port: req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-009 SHALL have port: req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-010 SHALL have port: req_ready  output  1  accepting a request this cycle.
REQ-011 SHALL have port: resp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port: resp_rdata  output  32  load result; 0 for stores and errors.
REQ-013 SHALL have port: resp_error  output  1  misaligned or illegal-size request, valid with resp_valid.
REQ-014 SHALL have port: data_bus_data  inout  32  shared tristate data bus.
REQ-015 SHALL have port: data_bus_addr  output  32  word-aligned bus address.
REQ-016 SHALL have port: data_bus_mode  output  2  00 idle, 01 read, 10 write.

Function
REQ-017 SHALL implement states IDLE, RD, RMW_RD, WR, RESP; req_ready = 1 only in IDLE.
REQ-018 SHALL accept a request on a rising edge with req_valid & req_ready and latch all req_* fields.
REQ-019 SHALL flag misalignment when: half with addr[0] = 1; word with addr[1:0] != 0; or size 11. Transition IDLE->RESP with resp_error = 1 and no bus cycle.
REQ-020 SHALL route loads IDLE->RD->RESP, word stores IDLE->WR->RESP, and byte/half stores IDLE->RMW_RD->WR->RESP.
REQ-021 SHALL drive data_bus_addr = {addr[31:2],2'b00} in RD, RMW_RD and WR, and 32'h0 in IDLE and RESP.
REQ-022 SHALL drive data_bus_mode = 01 in RD and RMW_RD, 10 in WR, and 00 otherwise.
REQ-023 SHALL drive data_bus_data only in WR and hold it at high-Z in every other state.
REQ-024 SHALL sample data_bus_data at the rising edge that ends RD or RMW_RD; read data is combinational from the peripheral within the same cycle.
REQ-025 SHALL extract load data little-endian: byte lane addr[1:0], half lane addr[1]. Extend per req_unsigned.
REQ-026 SHALL, in WR for a sub-word store, drive the sampled word with only the addressed byte/half lane replaced by req_wdata; word stores drive req_wdata unchanged.
REQ-027 SHALL assert resp_valid for exactly one cycle in RESP, then return to IDLE. resp_rdata and resp_error SHALL be 0 whenever resp_valid = 0.
REQ-028 SHALL give latency from the accepting edge to resp_valid high of: 1 cycle for errors, 2 for loads and word stores, 3 for sub-word stores.
REQ-029 SHALL ignore req_valid outside IDLE; a request held high is accepted on the first IDLE edge after RESP.

Reset
REQ-030 SHALL, while reset = 0 (asynchronously), force state IDLE, data_bus_mode 00, data_bus_addr 0, data_bus_data high-Z, resp_valid 0, resp_rdata 0, resp_error 0, and req_ready 1 after release.
REQ-031 SHALL drop any in-flight request on reset with no resp_valid and no further bus activity; the first edge after release may accept a new request.

Verification
REQ-032 Word store 0x000000A5 to 0x40F0 -> exactly one cycle of mode 10, addr 0x40F0, data 0x000000A5; resp_valid 2 cycles after accept; LED peripheral then reads 0xA5.
REQ-033 Signed byte load from 0x40F0 with bus returning 0x000000A5 -> one cycle of mode 01; resp_rdata 0xFFFFFFA5. The unsigned variant returns 0x000000A5.
REQ-034 Byte store 0x3C to 0x40F1 with memory word 0x11223344 -> read cycle at 0x40F0, then write cycle driving 0x11223C44; resp_valid 3 cycles after accept.
REQ-035 Half load from 0x40F1 -> resp_valid and resp_error 1 cycle after accept, resp_rdata 0, and data_bus_mode stays 00 throughout.
REQ-036 Reset asserted during WR -> mode 00 and data high-Z immediately without a clock edge; no resp_valid; the next request after release completes normally.
REQ-037 req_valid held high over back-to-back loads -> req_ready low from accept until RESP ends; the second request is accepted exactly one edge after RESP.
